cdd_host_seq: RTL and testbench
===============================

Name: cdd_host_seq

Overview:
- Host-side sequencer for the CD drive (CDD) nibble-serial link.
- On each drive interrupt it runs one full exchange: it receives 10 status nibbles, then sends 10 command nibbles, pacing every nibble with the HOCK/CDCK handshake.
- A single pending-command buffer is shared between CPU writes and an automatic NOP poll.
- Status is published to CPU-side registers and the CD IRQ logic.

Parameters:
- STEP_DIV, 12: CLK_12M cycles per sequencer step (1 MHz step rate).
- TIMEOUT, 4095: steps allowed waiting on one CDCK edge before abort.

Ports:
- CLK_12M  in  1  system clock
- RESET  in  1  asynchronous reset, active-high
- CD_nIRQ  in  1  drive interrupt, active-low, asynchronous
- CDCK  in  1  drive handshake clock, asynchronous
- CDD_DIN  in  4  nibble from drive
- HOCK  out  1  host handshake
- CDD_DOUT  out  4  nibble to drive
- cmd_wr  in  1  one-cycle strobe: load cmd_data into the pending buffer
- cmd_data  in  36  command nibbles 0..8; nibble n is bits [4n+3:4n]
- cmd_pending  out  1  buffer holds an unsent CPU command
- status_data  out  40  last received status nibbles 0..9
- status_valid  out  1  one-cycle pulse when status_data updates
- status_err  out  1  sticky; set on checksum mismatch
- timeout_err  out  1  sticky; set on handshake timeout
- err_clr  in  1  clears both sticky errors
- busy  out  1  exchange in progress

Behaviour:
- Input synchronisation:
  - CD_nIRQ, CDCK and CDD_DIN pass through 2-flop synchronisers.
  - IRQ event = synchronised CD_nIRQ falling edge.
- Step tick:
  - Counter 0..STEP_DIV-1; tick when the counter equals STEP_DIV-1.
  - All FSM transitions occur on tick only.
- Reset values:
  - HOCK=0, CDD_DOUT=0, busy=0, cmd_pending=0, status_data=0, status_valid=0, both errors=0.
  - FSM=IDLE; step and timeout counters=0.
- FSM states: IDLE, RX_HI, RX_LO, TX_SETUP, TX_HI, TX_LO, FINISH.
  - IDLE: an IRQ event is latched until the next tick. On that tick:
    - snapshot the command: the pending buffer if cmd_pending, else the NOP (all zero);
    - clear cmd_pending;
    - idx=0, busy=1, go RX_HI.
  - RX_HI: HOCK=1. When CDCK=1: latch CDD_DIN into nibble idx, HOCK=0.
    - idx=9: go TX_SETUP with idx=0. Do not wait for CDCK low; the drive holds CDCK high entering receive mode.
    - otherwise: go RX_LO.
  - RX_LO: HOCK=0. When CDCK=0: idx+1, go RX_HI.
  - TX_SETUP: CDD_DOUT = snapshot nibble idx (idx=9 outputs the checksum). Next tick go TX_HI, giving at least one step of setup.
  - TX_HI: HOCK=1. When CDCK=1: HOCK=0, go TX_LO.
  - TX_LO: When CDCK=0: idx=9 goes FINISH, else idx+1 and go TX_SETUP.
  - FINISH: status_valid pulses for exactly one CLK_12M cycle; busy=0; go IDLE.
- Checksum (4-bit, wraps mod 16):
  - chk = ~(4'd5 + sum of nibbles 0..8).
  - The TX nibble 9 is computed from the snapshot.
  - On RX, received nibble 9 is compared with chk of received nibbles 0..8.
- Timeout:
  - The counter clears on entering each wait state and increments per tick while waiting.
  - At TIMEOUT: set timeout_err, HOCK=0, busy=0, go IDLE.
  - status_data is not updated and status_valid does not pulse.
  - A snapshotted CPU command is restored to the buffer (cmd_pending=1) unless a newer cmd_wr arrived.
- Simultaneous and boundary events:
  - cmd_wr while cmd_pending=1: the new command overwrites (last write wins).
  - cmd_wr during an exchange: buffered for the next exchange; the current snapshot is unaffected.
  - cmd_wr in the same cycle as snapshot: the old buffer content is sent; the new command stays pending.
  - IRQ event while busy: ignored.
  - err_clr in the same cycle as an error set: set wins.
  - RESET mid-exchange: immediate return to reset values; HOCK drops asynchronously.

Optional Feature:
- CDD_STATUS_CHK_EN
  - Defined: a status checksum mismatch sets status_err. status_data still updates and status_valid still pulses.
  - Undefined: no comparison logic is built; status_err is tied to 0.

Decomposition:
- Shared package cdd_pkg:
  - FSM state enum;
  - NIBBLES=10;
  - CHK_SEED=4'd5;
  - function cdd_checksum over 9 nibbles, shared with the drive model.
- Sub-module cdd_sync: generic 2-flop synchroniser, instanced for CD_nIRQ, CDCK and the 4 CDD_DIN bits.

Test Plan:
- No cmd_wr; drive model returns status 0,1,2..8 + checksum on IRQ → NOP sent (nibbles 0, nibble 9 = 4'hA); status_data = 0x{chk}876543210; one status_valid pulse; no errors.
- cmd_wr with cmd_data nibble0=2, nibble3=4 (TOC first/last), then IRQ → sent nibbles 2,0,0,4,0,0,0,0,0, checksum 4'h4; cmd_pending falls at snapshot.
- Drive returns status with nibble 9 corrupted → status_err=1 with CDD_STATUS_CHK_EN, 0 without; status_valid pulses in both builds.
- Drive stalls CDCK low during RX_HI nibble 3 → HOCK high for exactly TIMEOUT ticks, then timeout_err=1, HOCK=0, busy=0, no status_valid; next IRQ completes normally.
- Two cmd_wr (A then B) before IRQ, plus cmd_wr C mid-exchange → B sent on the first exchange, C on the second, A never sent.
- RESET asserted during TX_HI → HOCK=0 and busy=0 asynchronously; after release, no exchange runs without a new IRQ.

Source files
------------

// File: rtl/cdd_host_seq_pkg.sv
// cdd_pkg: shared types and checksum for the CDD nibble-serial link.
// The checksum function is also used by drive-side models.
package cdd_pkg;

  localparam int         NIBBLES  = 10;
  localparam logic [3:0] CHK_SEED = 4'd5;

  typedef enum logic [2:0] {
    IDLE,
    RX_HI,
    RX_LO,
    TX_SETUP,
    TX_HI,
    TX_LO,
    FINISH
  } cdd_state_e;

  function automatic logic [3:0] cdd_checksum(
    input logic [35:0] n
  );
    logic [3:0] s;
    s = CHK_SEED;
    for (int i = 0; i < 9; i++) begin
      s = s + n[4*i +: 4];
    end
    return ~s;
  endfunction

endpackage

// File: rtl/cdd_host_seq_if.sv
// cdd_host_seq_if: CDD link between host and drive.
// Host side is master, drive side is slave.
interface cdd_host_seq_if;
  logic       CD_nIRQ;
  logic       CDCK;
  logic [3:0] CDD_DIN;
  logic       HOCK;
  logic [3:0] CDD_DOUT;

  modport master (
    input  CD_nIRQ,
    input  CDCK,
    input  CDD_DIN,
    output HOCK,
    output CDD_DOUT
  );

  modport slave (
    output CD_nIRQ,
    output CDCK,
    output CDD_DIN,
    input  HOCK,
    input  CDD_DOUT
  );
endinterface

// File: rtl/cdd_sync.sv
// cdd_sync: generic 2-flop synchroniser.
// RST_VAL sets the idle level seen while in reset.
module cdd_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK_12M,
  input  logic             RESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK_12M or posedge RESET) begin
    if (RESET) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdd_host_seq.sv
// cdd_host_seq: host sequencer for the CDD nibble-serial link.
// Define CDD_STATUS_CHK_EN to build the status checksum check.
module cdd_host_seq
  import cdd_pkg::*;
#(
  parameter int STEP_DIV = 12,
  parameter int TIMEOUT  = 4095
) (
  input  logic           CLK_12M,
  input  logic           RESET,
  cdd_host_seq_if.master cdd,
  input  logic           cmd_wr,
  input  logic [35:0]    cmd_data,
  output logic           cmd_pending,
  output logic [39:0]    status_data,
  output logic           status_valid,
  output logic           status_err,
  output logic           timeout_err,
  input  logic           err_clr,
  output logic           busy
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] step;
  logic          tick;
  logic          nirq_s;
  logic          nirq_q;
  logic          cdck_s;
  logic [3:0]    din_s;
  logic          irq_ev;
  logic          irq_lat;

  cdd_state_e    state;
  logic [3:0]    idx;
  logic [TW-1:0] to_cnt;
  logic          hock;
  logic [3:0]    dout;

  logic [NIBBLES-1:0][3:0] rx;
  logic [NIBBLES-1:0][3:0] snap;
  logic [35:0]   cmd_buf;
  logic [35:0]   snap_src;
  logic          snap_cpu;
  logic          wait_st;
  logic          go;
  logic          to_last;

  cdd_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_irq (
    .CLK_12M (CLK_12M),
    .RESET   (RESET),
    .d       (cdd.CD_nIRQ),
    .q       (nirq_s)
  );

  cdd_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_ck (
    .CLK_12M (CLK_12M),
    .RESET   (RESET),
    .d       (cdd.CDCK),
    .q       (cdck_s)
  );

  cdd_sync #(.WIDTH(4), .RST_VAL(4'h0)) u_sync_din (
    .CLK_12M (CLK_12M),
    .RESET   (RESET),
    .d       (cdd.CDD_DIN),
    .q       (din_s)
  );

  assign cdd.HOCK     = hock;
  assign cdd.CDD_DOUT = dout;

  assign tick     = step == SW'(STEP_DIV - 1);
  assign irq_ev   = nirq_q & ~nirq_s;
  assign snap_src = cmd_pending ? cmd_buf : '0;
  assign wait_st  = state inside {RX_HI, RX_LO, TX_HI, TX_LO};
  assign go       = (state == RX_HI || state == TX_HI)
                  ? cdck_s : ~cdck_s;
  assign to_last  = to_cnt == TW'(TIMEOUT - 1);

  always_ff @(posedge CLK_12M or posedge RESET) begin
    if (RESET) begin
      step   <= '0;
      nirq_q <= 1'b1;
    end else begin
      step   <= tick ? '0 : step + 1'b1;
      nirq_q <= nirq_s;
    end
  end

  always_ff @(posedge CLK_12M or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      idx          <= '0;
      to_cnt       <= '0;
      irq_lat      <= 1'b0;
      hock         <= 1'b0;
      dout         <= '0;
      busy         <= 1'b0;
      cmd_pending  <= 1'b0;
      cmd_buf      <= '0;
      snap         <= '0;
      snap_cpu     <= 1'b0;
      rx           <= '0;
      status_data  <= '0;
      status_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      if (cmd_wr) begin
        cmd_buf     <= cmd_data;
        cmd_pending <= 1'b1;
      end
      if (irq_ev && state == IDLE) irq_lat <= 1'b1;
      if (state == TX_SETUP) dout <= snap[idx];
      if (tick) begin
        unique case (state)
          IDLE: if (irq_lat || irq_ev) begin
            // a write in this same cycle stays pending
            snap     <= {cdd_checksum(snap_src), snap_src};
            snap_cpu <= cmd_pending;
            if (!cmd_wr) cmd_pending <= 1'b0;
            irq_lat  <= 1'b0;
            idx      <= '0;
            to_cnt   <= '0;
            busy     <= 1'b1;
            hock     <= 1'b1;
            state    <= RX_HI;
          end
          RX_HI: if (go) begin
            rx[idx] <= din_s;
            hock    <= 1'b0;
            to_cnt  <= '0;
            if (idx == 4'(NIBBLES - 1)) begin
              idx   <= '0;
              state <= TX_SETUP;
            end else begin
              state <= RX_LO;
            end
          end
          RX_LO: if (go) begin
            idx    <= idx + 4'd1;
            hock   <= 1'b1;
            to_cnt <= '0;
            state  <= RX_HI;
          end
          TX_SETUP: begin
            hock   <= 1'b1;
            to_cnt <= '0;
            state  <= TX_HI;
          end
          TX_HI: if (go) begin
            hock   <= 1'b0;
            to_cnt <= '0;
            state  <= TX_LO;
          end
          TX_LO: if (go) begin
            to_cnt <= '0;
            if (idx == 4'(NIBBLES - 1)) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 4'd1;
              state <= TX_SETUP;
            end
          end
          FINISH: begin
            status_data  <= rx;
            status_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
        if (wait_st && !go) begin
          if (to_last) begin
            timeout_err <= 1'b1;
            hock        <= 1'b0;
            busy        <= 1'b0;
            to_cnt      <= '0;
            state       <= IDLE;
            if (snap_cpu) cmd_pending <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef CDD_STATUS_CHK_EN
  logic st_err;

  always_ff @(posedge CLK_12M or posedge RESET) begin
    if (RESET) begin
      st_err <= 1'b0;
    end else begin
      if (err_clr) st_err <= 1'b0;
      if (tick && state == FINISH &&
          rx[9] != cdd_checksum(rx[8:0]))
        st_err <= 1'b1;
    end
  end

  assign status_err = st_err;
`else
  assign status_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdd_host_seq.sv
// tb_cdd_host_seq: randomized drive model and scoreboard
// for the CDD host sequencer.
module tb_cdd_host_seq;

  localparam int STEP_DIV = 12;
  localparam int TIMEOUT  = 300;
  localparam int LIM      = 3000;

`ifdef CDD_STATUS_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_wr = 1'b0;
  logic [35:0] cmd_data = '0;
  logic        cmd_pending;
  logic [39:0] status_data;
  logic        status_valid;
  logic        status_err;
  logic        timeout_err;
  logic        err_clr = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;
  int vcount = 0;
  int long_pulse = 0;
  bit sv_prev = 1'b0;

  bit          m_pend = 1'b0;
  logic [35:0] m_buf = '0;

  cdd_host_seq_if cdd();

  cdd_host_seq #(
    .STEP_DIV (STEP_DIV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK_12M      (clk),
    .RESET        (rst),
    .cdd          (cdd),
    .cmd_wr       (cmd_wr),
    .cmd_data     (cmd_data),
    .cmd_pending  (cmd_pending),
    .status_data  (status_data),
    .status_valid (status_valid),
    .status_err   (status_err),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (status_valid) vcount <= vcount + 1;
    if (status_valid && sv_prev) long_pulse <= long_pulse + 1;
    sv_prev <= status_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] ref_chk(input logic [35:0] c);
    int s;
    s = 5;
    for (int i = 0; i < 9; i++) s += int'(c[4*i +: 4]);
    return ~4'(s % 16);
  endfunction

  function automatic logic [35:0] take();
    logic [35:0] e;
    e = m_pend ? m_buf : 36'h0;
    m_pend = 1'b0;
    return e;
  endfunction

  task automatic wr_cmd(input logic [35:0] d);
    @(negedge clk);
    cmd_data = d;
    cmd_wr = 1'b1;
    @(negedge clk);
    cmd_wr = 1'b0;
    m_buf = d;
    m_pend = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wait_hock(input logic v, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < LIM; k++) begin
      if (cdd.HOCK === v) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL hock_wait: HOCK=%b required %b", cdd.HOCK, v);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < LIM) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_wait: busy=%b required 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  // drive side: send st on RX, capture host nibbles on TX
  task automatic drive(input logic [39:0] st, input int stall_rx,
                       input int stall_tx, output logic [39:0] sent,
                       output bit stopped);
    bit ok;
    sent = '0;
    stopped = 1'b0;
    @(negedge clk);
    cdd.CD_nIRQ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_hock(1'b1, ok);
      if (i == 0) cdd.CD_nIRQ = 1'b1;
      if (!ok || i == stall_rx) begin
        stopped = 1'b1;
        return;
      end
      repeat ($urandom_range(0, 15)) @(negedge clk);
      cdd.CDD_DIN = st[4*i +: 4];
      @(negedge clk);
      cdd.CDCK = 1'b1;
      wait_hock(1'b0, ok);
      if (!ok) begin
        stopped = 1'b1;
        return;
      end
      if (i < 9) begin
        repeat ($urandom_range(0, 15)) @(negedge clk);
        cdd.CDCK = 1'b0;
      end
    end
    for (int j = 0; j < 10; j++) begin
      wait_hock(1'b1, ok);
      if (!ok || j == stall_tx) begin
        stopped = 1'b1;
        return;
      end
      sent[4*j +: 4] = cdd.CDD_DOUT;
      repeat ($urandom_range(0, 15)) @(negedge clk);
      cdd.CDCK = 1'b1;
      wait_hock(1'b0, ok);
      if (!ok) begin
        stopped = 1'b1;
        return;
      end
      repeat ($urandom_range(0, 15)) @(negedge clk);
      cdd.CDCK = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (cdd.HOCK !== 1'b0) begin bad++;
      $display("FAIL rst_hock: got %b want 0", cdd.HOCK); end
    total++; if (cdd.CDD_DOUT !== 4'h0) begin bad++;
      $display("FAIL rst_dout: got %h want 0", cdd.CDD_DOUT); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (cmd_pending !== 1'b0) begin bad++;
      $display("FAIL rst_pend: got %b want 0", cmd_pending); end
    total++; if (status_data !== 40'h0) begin bad++;
      $display("FAIL rst_sdata: got %h want 0", status_data); end
    total++; if (status_valid !== 1'b0) begin bad++;
      $display("FAIL rst_svalid: got %b want 0", status_valid); end
    total++; if (status_err !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_err: got %b%b want 00",
               status_err, timeout_err); end
    rst = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (busy !== 1'b0 || cdd.HOCK !== 1'b0) begin bad++;
      $display("FAIL rst_idle: busy=%b hock=%b want 0 0",
               busy, cdd.HOCK); end
  endtask

  task automatic test_nop();
    logic [39:0] st;
    logic [39:0] sent;
    logic [35:0] e;
    bit stp;
    int v0;
    st = {ref_chk(36'h876543210), 36'h876543210};
    e = take();
    v0 = vcount;
    drive(st, -1, -1, sent, stp);
    wait_idle();
    total++; if (sent !== 40'hA000000000 ||
                 sent !== {ref_chk(e), e}) begin bad++;
      $display("FAIL nop_sent: got %h want A000000000", sent); end
    total++; if (status_data !== 40'h6876543210) begin bad++;
      $display("FAIL nop_sdata: got %h want 6876543210",
               status_data); end
    total++; if (vcount !== v0 + 1) begin bad++;
      $display("FAIL nop_valid: got %0d pulses want 1", vcount - v0); end
    total++; if (status_err !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL nop_err: got %b%b want 00",
               status_err, timeout_err); end
  endtask

  task automatic test_toc();
    logic [39:0] st;
    logic [39:0] sent;
    logic [35:0] e;
    logic [35:0] s9;
    bit stp;
    s9 = {4'($urandom), 32'($urandom)};
    st = {ref_chk(s9), s9};
    wr_cmd(36'h000004002);
    total++; if (cmd_pending !== 1'b1) begin bad++;
      $display("FAIL toc_pend_set: got %b want 1", cmd_pending); end
    e = take();
    fork
      drive(st, -1, -1, sent, stp);
      begin
        for (int k = 0; k < LIM && busy !== 1'b1; k++)
          @(negedge clk);
        total++; if (busy !== 1'b1 || cmd_pending !== 1'b0) begin
          bad++;
          $display("FAIL toc_pend_fall: busy=%b pend=%b want 1 0",
                   busy, cmd_pending); end
      end
    join
    wait_idle();
    total++; if (sent !== 40'h4000004002 ||
                 sent !== {ref_chk(e), e}) begin bad++;
      $display("FAIL toc_sent: got %h want 4000004002", sent); end
    total++; if (status_data !== st) begin bad++;
      $display("FAIL toc_sdata: got %h want %h", status_data, st); end
  endtask

  task automatic test_bad_chk();
    logic [39:0] st;
    logic [39:0] sent;
    logic [35:0] s9;
    logic [35:0] e;
    bit stp;
    int v0;
    s9 = {4'($urandom), 32'($urandom)};
    st = {ref_chk(s9) ^ 4'h3, s9};
    e = take();
    v0 = vcount;
    drive(st, -1, -1, sent, stp);
    wait_idle();
    total++; if (status_err !== CHK_EN) begin bad++;
      $display("FAIL badchk_err: got %b want %b", status_err, CHK_EN); end
    total++; if (vcount !== v0 + 1 || status_data !== st) begin bad++;
      $display("FAIL badchk_status: pulses=%0d data=%h want 1 %h",
               vcount - v0, status_data, st); end
    total++; if (sent !== {ref_chk(e), e}) begin bad++;
      $display("FAIL badchk_sent: got %h want %h",
               sent, {ref_chk(e), e}); end
    pulse_clr();
    total++; if (status_err !== 1'b0) begin bad++;
      $display("FAIL badchk_clr: got %b want 0", status_err); end
  endtask

  task automatic test_timeout();
    logic [39:0] st;
    logic [39:0] sent;
    logic [35:0] c;
    logic [35:0] e;
    bit stp;
    bit was_cpu;
    int v0;
    int cnt;
    c = {4'($urandom), 32'($urandom)};
    st = {ref_chk(36'h123456789), 36'h123456789};
    wr_cmd(c);
    was_cpu = m_pend;
    e = take();
    v0 = vcount;
    drive(st, 3, -1, sent, stp);
    cnt = 1;
    @(negedge clk);
    while (cdd.HOCK === 1'b1 && cnt < TIMEOUT * STEP_DIV + 100) begin
      cnt++;
      @(negedge clk);
    end
    m_pend = m_pend | was_cpu;
    total++; if (stp !== 1'b1 || cnt !== TIMEOUT * STEP_DIV) begin
      bad++;
      $display("FAIL to_len: hock high %0d cycles want %0d",
               cnt, TIMEOUT * STEP_DIV); end
    total++; if (timeout_err !== 1'b1) begin bad++;
      $display("FAIL to_err: got %b want 1", timeout_err); end
    total++; if (busy !== 1'b0 || cdd.HOCK !== 1'b0) begin bad++;
      $display("FAIL to_idle: busy=%b hock=%b want 0 0",
               busy, cdd.HOCK); end
    total++; if (vcount !== v0) begin bad++;
      $display("FAIL to_valid: got %0d pulses want 0", vcount - v0); end
    total++; if (cmd_pending !== m_pend || e !== c) begin bad++;
      $display("FAIL to_restore: pend=%b want %b", cmd_pending, m_pend); end
    e = take();
    drive(st, -1, -1, sent, stp);
    wait_idle();
    total++; if (sent !== {ref_chk(e), e} || status_data !== st) begin
      bad++;
      $display("FAIL to_retry: sent=%h data=%h want %h %h",
               sent, status_data, {ref_chk(e), e}, st); end
    total++; if (timeout_err !== 1'b1) begin bad++;
      $display("FAIL to_sticky: got %b want 1", timeout_err); end
    pulse_clr();
    total++; if (timeout_err !== 1'b0) begin bad++;
      $display("FAIL to_clr: got %b want 0", timeout_err); end
  endtask

  task automatic test_last_write();
    logic [39:0] st;
    logic [39:0] sent;
    logic [35:0] a;
    logic [35:0] b;
    logic [35:0] c;
    logic [35:0] e;
    bit stp;
    a = {4'($urandom), 32'($urandom)};
    b = a ^ 36'h111111111;
    c = a ^ 36'h222222222;
    st = {ref_chk(36'h0), 36'h0};
    wr_cmd(a);
    wr_cmd(b);
    e = take();
    fork
      drive(st, -1, -1, sent, stp);
      begin
        for (int k = 0; k < LIM && busy !== 1'b1; k++)
          @(negedge clk);
        repeat (30) @(negedge clk);
        wr_cmd(c);
        total++; if (cmd_pending !== 1'b1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL lw_mid: pend=%b busy=%b want 1 1",
                   cmd_pending, busy); end
      end
    join
    wait_idle();
    total++; if (sent !== {ref_chk(e), e} || e !== b) begin bad++;
      $display("FAIL lw_first: got %h want %h",
               sent, {ref_chk(b), b}); end
    e = take();
    drive(st, -1, -1, sent, stp);
    wait_idle();
    total++; if (sent !== {ref_chk(e), e} || e !== c) begin bad++;
      $display("FAIL lw_second: got %h want %h",
               sent, {ref_chk(c), c}); end
    total++; if (cmd_pending !== 1'b0) begin bad++;
      $display("FAIL lw_pend: got %b want 0", cmd_pending); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [39:0] st;
      logic [39:0] sent;
      logic [35:0] s9;
      logic [35:0] e;
      logic [3:0]  k;
      bit corrupt;
      bit stp;
      int v0;
      if ($urandom_range(0, 1) == 1)
        wr_cmd({4'($urandom), 32'($urandom)});
      if ($urandom_range(0, 3) == 0)
        wr_cmd({4'($urandom), 32'($urandom)});
      s9 = {4'($urandom), 32'($urandom)};
      corrupt = $urandom_range(0, 3) == 0;
      k = ref_chk(s9) ^ (corrupt ? 4'($urandom_range(1, 15)) : 4'h0);
      st = {k, s9};
      e = take();
      v0 = vcount;
      drive(st, -1, -1, sent, stp);
      wait_idle();
      total++; if (stp !== 1'b0 || sent !== {ref_chk(e), e}) begin
        bad++;
        $display("FAIL rnd_sent[%0d]: got %h want %h",
                 r, sent, {ref_chk(e), e}); end
      total++; if (status_data !== st || vcount !== v0 + 1) begin
        bad++;
        $display("FAIL rnd_status[%0d]: data=%h pulses=%0d want %h 1",
                 r, status_data, vcount - v0, st); end
      total++; if (status_err !== (CHK_EN & corrupt)) begin bad++;
        $display("FAIL rnd_err[%0d]: got %b want %b",
                 r, status_err, CHK_EN & corrupt); end
      total++; if (cmd_pending !== m_pend || timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL rnd_flags[%0d]: pend=%b terr=%b want %b 0",
                 r, cmd_pending, timeout_err, m_pend); end
      pulse_clr();
    end
    total++; if (long_pulse !== 0) begin bad++;
      $display("FAIL valid_width: got %0d long pulses want 0",
               long_pulse); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] st;
    logic [39:0] sent;
    bit stp;
    int seen;
    st = {ref_chk(36'h0), 36'h0};
    drive(st, -1, 2, sent, stp);
    #2;
    rst = 1'b1;
    #1;
    total++; if (stp !== 1'b1 || cdd.HOCK !== 1'b0) begin bad++;
      $display("FAIL rmid_hock: got %b want 0", cdd.HOCK); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rmid_busy: got %b want 0", busy); end
    cdd.CDCK = 1'b0;
    cdd.CDD_DIN = 4'h0;
    cdd.CD_nIRQ = 1'b1;
    m_pend = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (60 * STEP_DIV) begin
      @(negedge clk);
      if (busy !== 1'b0 || cdd.HOCK !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++;
      $display("FAIL rmid_norun: active %0d cycles want 0", seen); end
    total++; if (status_data !== 40'h0 || cmd_pending !== m_pend) begin
      bad++;
      $display("FAIL rmid_regs: data=%h pend=%b want 0 0",
               status_data, cmd_pending); end
  endtask

  initial begin
    cdd.CD_nIRQ = 1'b1;
    cdd.CDCK = 1'b0;
    cdd.CDD_DIN = 4'h0;
    test_reset();
    test_nop();
    test_toc();
    test_bad_chk();
    test_timeout();
    test_last_write();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
